// File: rtl/stv_width_packer.sv
// stv_width_packer: collects RATIO narrow beats into one wide word for a
// downstream wide FIFO. A din_last beat closes a partial word early, and
// dout_keep marks which lanes of that word were actually written.
module stv_width_packer #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO = 4,
    localparam int OUT_WIDTH = IN_WIDTH * RATIO,
    localparam int IDXWIDTH = $clog2(RATIO)
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 clear,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 din_last,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [OUT_WIDTH-1:0] dout,
    output logic [RATIO-1:0]     dout_keep,
    output logic                 dout_last,
    output logic [IDXWIDTH-1:0]  lane
);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t state;

    logic                 accept;
    logic                 pop;
    logic                 close;
    logic [OUT_WIDTH-1:0] word_ins;
    logic [RATIO-1:0]     keep_ins;

    // The buffer itself is the output register, so a held word never changes.
    assign dout_valid = (state == HOLD);
    assign din_ready  = !dout_valid || dout_ready;
    assign accept     = din_valid && din_ready;
    assign pop        = dout_valid && dout_ready;
    assign close      = (lane == IDXWIDTH'(RATIO - 1)) || din_last;

    // Merge the incoming beat into its lane; a word leaving this cycle is replaced by an empty one first.
    always_comb begin
        word_ins = pop ? '0 : dout;
        keep_ins = pop ? '0 : dout_keep;
        word_ins[int'(lane) * IN_WIDTH +: IN_WIDTH] = din;
        keep_ins[lane] = 1'b1;
    end

    // FILL/HOLD state machine owning the buffer, keep mask, last flag and fill level.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= FILL;
            lane      <= '0;
            dout      <= '0;
            dout_keep <= '0;
            dout_last <= 1'b0;
        end else if (clear) begin
            state     <= FILL;
            lane      <= '0;
            dout      <= '0;
            dout_keep <= '0;
            dout_last <= 1'b0;
        end else if (accept) begin
            dout      <= word_ins;
            dout_keep <= keep_ins;
            if (close) begin
                state     <= HOLD;
                lane      <= '0;
                dout_last <= din_last;
            end else begin
                state     <= FILL;
                lane      <= lane + IDXWIDTH'(1);
                dout_last <= 1'b0;
            end
        end else if (pop) begin
            state     <= FILL;
            dout      <= '0;
            dout_keep <= '0;
            dout_last <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    // A packer needs at least two lanes to pack anything.
    if (RATIO < 2) begin : g_bad_ratio
        $error("stv_width_packer: RATIO must be greater than 1");
    end

    // A stalled output word must stay put until the consumer takes it.
    a_hold_stable : assert property (@(posedge clk) disable iff (!arst_n)
        (dout_valid && !dout_ready && !clear) |=>
        (dout_valid && $stable(dout) && $stable(dout_keep) && $stable(dout_last)));

    // A producer that is back-pressured must keep offering the same beat.
    a_din_stable : assert property (@(posedge clk) disable iff (!arst_n)
        (din_valid && !din_ready && !clear) |=>
        (clear || (din_valid && $stable(din))));
`endif

endmodule
